// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - shared-ALU request/response bus used by the multiply sequencer
//
// Purpose: bundles the opcode/operand/shift-amount request and the
// combinational result returned by a shared ALU in the same cycle.
//
// Signals:
//   alu_operation  4  ALU opcode (AND=0000, ADD=0011, SLL=0101, SRL=0110)
//   alu_a         32  operand A
//   alu_b         32  operand B
//   alu_shamt      5  shift amount
//   alu_result    32  combinational result from the ALU
//
// Modports:
//   master - the sequencer: drives the request, reads the result
//   slave  - the ALU: reads the request, drives the result

interface alu_mult_sequencer_if;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;

    modport master (
        output alu_operation,
        output alu_a,
        output alu_b,
        output alu_shamt,
        input  alu_result
    );

    modport slave (
        input  alu_operation,
        input  alu_a,
        input  alu_b,
        input  alu_shamt,
        output alu_result
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-and-add 32x32 multiplier that borrows a shared ALU
//
// Purpose: computes the low 32 bits of multiplicand*multiplier by iterating
// ADD -> SHL -> SHR once per multiplier bit, using an external combinational
// ALU for every arithmetic step. Iteration stops early once the remaining
// multiplier bits are all zero.
//
// Ports:
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous active-high reset
//   start         in   1   begin a multiply (only honoured in IDLE)
//   multiplicand  in  32   operand M, captured on the accepting edge
//   multiplier    in  32   operand Q, captured on the accepting edge
//   alu           if       master side of the shared ALU bus
//   product       out 32   registered result, held until the next completion
//   busy          out  1   high while iterating (ADD/SHL/SHR)
//   done          out  1   one-cycle completion pulse

module alu_mult_sequencer (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 multiplicand,
    input  logic [31:0]                 multiplier,
    alu_mult_sequencer_if.master        alu,
    output logic [31:0]                 product,
    output logic                        busy,
    output logic                        done
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  iter;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero multiplier needs no iterations at all.
                    state_next = (multiplier == 32'd0) ? S_DONE : S_ADD;
                end
            end
            S_ADD:  state_next = S_SHL;
            S_SHL:  state_next = S_SHR;
            S_SHR: begin
                // alu_result is the shifted multiplier; once it is zero no
                // further partial products can contribute. iter==31 here
                // means this is the 32nd pass.
                if ((alu.alu_result == 32'd0) || (iter == 6'd31)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ADD;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: ALU request and status depend only on state/registers.
    // While reset is asserted everything reads as in IDLE.
    always_comb begin
        alu.alu_operation = OP_AND;
        alu.alu_a         = 32'd0;
        alu.alu_b         = 32'd0;
        alu.alu_shamt     = 5'd0;
        busy              = 1'b0;
        done              = 1'b0;
        if (!reset) begin
            case (state)
                S_ADD: begin
                    alu.alu_operation = OP_ADD;
                    alu.alu_a         = acc;
                    alu.alu_b         = mcand;
                    busy              = 1'b1;
                end
                S_SHL: begin
                    alu.alu_operation = OP_SLL;
                    alu.alu_b         = mcand;
                    alu.alu_shamt     = 5'd1;
                    busy              = 1'b1;
                end
                S_SHR: begin
                    alu.alu_operation = OP_SRL;
                    alu.alu_b         = mplier;
                    alu.alu_shamt     = 5'd1;
                    busy              = 1'b1;
                end
                S_DONE: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 32'd0;
            mcand   <= 32'd0;
            mplier  <= 32'd0;
            iter    <= 6'd0;
            product <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= multiplicand;
                        mplier <= multiplier;
                        acc    <= 32'd0;
                        iter   <= 6'd0;
                    end
                end
                S_ADD: begin
                    // Only accumulate the partial product for a set bit.
                    if (mplier[0]) begin
                        acc <= alu.alu_result;
                    end
                end
                S_SHL: begin
                    mcand <= alu.alu_result;
                end
                S_SHR: begin
                    mplier <= alu.alu_result;
                    iter   <= iter + 6'd1;
                end
                S_DONE: begin
                    // acc was cleared on acceptance, so a zero multiplier
                    // that skipped straight here publishes 0.
                    product <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - directed self-checking bench for alu_mult_sequencer

module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mult_sequencer_if alu_bus ();

    alu_mult_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .alu          (alu_bus),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference shared ALU
    always_comb begin
        case (alu_bus.alu_operation)
            4'b0000: alu_bus.alu_result = alu_bus.alu_a & alu_bus.alu_b;
            4'b0011: alu_bus.alu_result = alu_bus.alu_a + alu_bus.alu_b;
            4'b0101: alu_bus.alu_result = alu_bus.alu_b << alu_bus.alu_shamt;
            4'b0110: alu_bus.alu_result = alu_bus.alu_b >> alu_bus.alu_shamt;
            default: alu_bus.alu_result = 32'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one multiply from IDLE and gathers observations (no checking here).
    task automatic run_mul(input logic [31:0] m, input logic [31:0] q, input bit repulse,
                           output int done_cyc, output int done_cnt, output int busy_cnt,
                           output int op_err, output int prod_early, output int acc_writes);
        logic [31:0] p0;
        logic [31:0] acc_prev;
        logic [3:0]  exp_op;
        int          tail;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; op_err = 0; prod_early = 0; acc_writes = 0;
        tail = 0;
        p0 = product;
        start = 1'b1; multiplicand = m; multiplier = q;
        step();
        start = 1'b0; multiplicand = 32'hDEADBEEF; multiplier = 32'hCAFEF00D;
        acc_prev = dut.acc;
        for (int k = 1; k <= 200 && tail < 4; k++) begin
            if (busy) begin
                case (busy_cnt % 3)
                    0:       exp_op = 4'b0011;
                    1:       exp_op = 4'b0101;
                    default: exp_op = 4'b0110;
                endcase
                if (alu_bus.alu_operation !== exp_op) op_err++;
                busy_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if ((done_cyc < 0 || k == done_cyc) && product !== p0) prod_early++;
            if (dut.acc !== acc_prev) acc_writes++;
            acc_prev = dut.acc;
            if (done_cyc >= 0) tail++;
            start = repulse && (k == 2 || k == 4 || k == 7);
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; multiplicand = 32'd0; multiplier = 32'd0;
        step();
        step();
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b expected 0", busy); n_fail++; end
        n_checks++;
        if (done !== 1'b0) begin $display("FAIL reset_done: got %0b expected 0", done); n_fail++; end
        n_checks++;
        if (product !== 32'd0) begin $display("FAIL reset_product: got %h expected 0", product); n_fail++; end
        n_checks++;
        if (alu_bus.alu_operation !== 4'b0000 || alu_bus.alu_a !== 32'd0 || alu_bus.alu_b !== 32'd0 || alu_bus.alu_shamt !== 5'd0) begin
            $display("FAIL reset_alu: got op=%b a=%h b=%h sh=%0d expected all 0",
                     alu_bus.alu_operation, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_shamt);
            n_fail++;
        end
        n_checks++;
        // reset and start on the same edge: reset must win
        start = 1'b1; multiplicand = 32'd6; multiplier = 32'd7;
        step();
        reset = 1'b0; start = 1'b0;
        step();
        if (busy !== 1'b0) begin $display("FAIL reset_priority_busy: got %0b expected 0", busy); n_fail++; end
        n_checks++;
        if (done !== 1'b0) begin $display("FAIL reset_priority_done: got %0b expected 0", done); n_fail++; end
        n_checks++;
    endtask

    task automatic test_basic();
        int dc, dn, bc, oe, pe, aw;
        run_mul(32'd6, 32'd7, 1'b0, dc, dn, bc, oe, pe, aw);
        if (dc !== 10) begin $display("FAIL basic_done_cycle: got %0d expected 10", dc); n_fail++; end
        n_checks++;
        if (bc !== 9) begin $display("FAIL basic_busy_cycles: got %0d expected 9", bc); n_fail++; end
        n_checks++;
        if (dn !== 1) begin $display("FAIL basic_done_pulses: got %0d expected 1", dn); n_fail++; end
        n_checks++;
        if (product !== 32'd42) begin $display("FAIL basic_product: got %0d expected 42", product); n_fail++; end
        n_checks++;
        if (oe !== 0) begin $display("FAIL basic_op_seq: got %0d bad opcodes expected 0", oe); n_fail++; end
        n_checks++;
        if (pe !== 0) begin $display("FAIL basic_product_hold: got %0d early changes expected 0", pe); n_fail++; end
        n_checks++;
    endtask

    task automatic test_q_zero();
        int dc, dn, bc, oe, pe, aw;
        run_mul(32'h12345678, 32'd0, 1'b0, dc, dn, bc, oe, pe, aw);
        if (dc !== 1) begin $display("FAIL qzero_done_cycle: got %0d expected 1", dc); n_fail++; end
        n_checks++;
        if (bc !== 0) begin $display("FAIL qzero_busy_cycles: got %0d expected 0", bc); n_fail++; end
        n_checks++;
        if (product !== 32'd0) begin $display("FAIL qzero_product: got %h expected 0", product); n_fail++; end
        n_checks++;
        if (pe !== 0) begin $display("FAIL qzero_product_hold: got %0d early changes expected 0", pe); n_fail++; end
        n_checks++;
    endtask

    task automatic test_full_width();
        int dc, dn, bc, oe, pe, aw;
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, dc, dn, bc, oe, pe, aw);
        if (dc !== 97) begin $display("FAIL full_done_cycle: got %0d expected 97", dc); n_fail++; end
        n_checks++;
        if (bc !== 96) begin $display("FAIL full_busy_cycles: got %0d expected 96", bc); n_fail++; end
        n_checks++;
        if (product !== 32'h00000001) begin $display("FAIL full_product: got %h expected 00000001", product); n_fail++; end
        n_checks++;
        if (oe !== 0) begin $display("FAIL full_op_seq: got %0d bad opcodes expected 0", oe); n_fail++; end
        n_checks++;
    endtask

    task automatic test_msb_only();
        int dc, dn, bc, oe, pe, aw;
        run_mul(32'd3, 32'h80000000, 1'b0, dc, dn, bc, oe, pe, aw);
        if (dc !== 97) begin $display("FAIL msb_done_cycle: got %0d expected 97", dc); n_fail++; end
        n_checks++;
        if (product !== 32'h80000000) begin $display("FAIL msb_product: got %h expected 80000000", product); n_fail++; end
        n_checks++;
        if (aw !== 1) begin $display("FAIL msb_acc_writes: got %0d expected 1", aw); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        int dc, dn, bc, oe, pe, aw;
        int done_seen, busy_seen;
        start = 1'b1; multiplicand = 32'd5; multiplier = 32'd9;
        step();
        start = 1'b0;
        if (alu_bus.alu_operation !== 4'b0011) begin $display("FAIL mid_add_op: got %b expected 0011", alu_bus.alu_operation); n_fail++; end
        n_checks++;
        step();
        if (alu_bus.alu_operation !== 4'b0101) begin $display("FAIL mid_shl_op: got %b expected 0101", alu_bus.alu_operation); n_fail++; end
        n_checks++;
        reset = 1'b1;
        #1;
        if (busy !== 1'b0 || alu_bus.alu_operation !== 4'b0000 || alu_bus.alu_b !== 32'd0) begin
            $display("FAIL mid_reset_outputs: got busy=%0b op=%b b=%h expected 0/0000/0", busy, alu_bus.alu_operation, alu_bus.alu_b);
            n_fail++;
        end
        n_checks++;
        step();
        reset = 1'b0;
        if (product !== 32'd0) begin $display("FAIL mid_reset_product: got %h expected 0", product); n_fail++; end
        n_checks++;
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
            step();
        end
        if (done_seen !== 0 || busy_seen !== 0) begin
            $display("FAIL mid_reset_abort: got done=%0d busy=%0d cycles expected 0/0", done_seen, busy_seen);
            n_fail++;
        end
        n_checks++;
        run_mul(32'd5, 32'd9, 1'b0, dc, dn, bc, oe, pe, aw);
        if (dc !== 13) begin $display("FAIL mid_rerun_done_cycle: got %0d expected 13", dc); n_fail++; end
        n_checks++;
        if (product !== 32'd45) begin $display("FAIL mid_rerun_product: got %0d expected 45", product); n_fail++; end
        n_checks++;
    endtask

    task automatic test_busy_repulse();
        int dc, dn, bc, oe, pe, aw;
        run_mul(32'd2, 32'd3, 1'b1, dc, dn, bc, oe, pe, aw);
        if (dc !== 7) begin $display("FAIL repulse_done_cycle: got %0d expected 7", dc); n_fail++; end
        n_checks++;
        if (dn !== 1) begin $display("FAIL repulse_done_pulses: got %0d expected 1", dn); n_fail++; end
        n_checks++;
        if (bc !== 6) begin $display("FAIL repulse_busy_cycles: got %0d expected 6", bc); n_fail++; end
        n_checks++;
        if (product !== 32'd6) begin $display("FAIL repulse_product: got %0d expected 6", product); n_fail++; end
        n_checks++;
        if (oe !== 0) begin $display("FAIL repulse_op_seq: got %0d bad opcodes expected 0", oe); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd, busy9;
        logic [31:0] p_first;
        d1 = -1; d2 = -1; nd = 0; busy9 = 0; p_first = 32'hX;
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd3;
        step();
        multiplicand = 32'd5;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
            end
            if (k == 8) p_first = product;
            if (k == 9) begin
                busy9 = busy;
                start = 1'b0;
            end
            step();
        end
        if (d1 !== 7 || d2 !== 15) begin $display("FAIL b2b_done_cycles: got %0d,%0d expected 7,15", d1, d2); n_fail++; end
        n_checks++;
        if (nd !== 2) begin $display("FAIL b2b_done_pulses: got %0d expected 2", nd); n_fail++; end
        n_checks++;
        if (busy9 !== 1) begin $display("FAIL b2b_restart_busy: got %0d expected 1", busy9); n_fail++; end
        n_checks++;
        if (p_first !== 32'd6) begin $display("FAIL b2b_first_product: got %0d expected 6", p_first); n_fail++; end
        n_checks++;
        if (product !== 32'd15) begin $display("FAIL b2b_second_product: got %0d expected 15", product); n_fail++; end
        n_checks++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; multiplicand = 32'd0; multiplier = 32'd0;
        #1;
        test_reset();
        test_basic();
        test_q_zero();
        test_full_width();
        test_msb_only();
        test_reset_mid();
        test_busy_repulse();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mult_sequencer.md
ALU_MULT_SEQUENCER -- requirements
Module: alu_mult_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 Port: multiplicand  input  32  operand M; sampled on the accepting edge.
REQ-007 Port: multiplier  input  32  operand Q; sampled on the accepting edge.
REQ-008 Port: alu_result  input  32  combinational result returned by the shared ALU in the same cycle.
REQ-009 Port: alu_operation  output  4  ALU opcode; AND=0000, ADD=0011, SLL=0101, SRL=0110.
REQ-010 Port: alu_a  output  32  ALU operand A.
REQ-011 Port: alu_b  output  32  ALU operand B.
REQ-012 Port: alu_shamt  output  5  ALU shift amount.
REQ-013 Port: product  output  32  low 32 bits of M*Q; registered; held until the next accepted start.
REQ-014 Port: busy  output  1  high in states ADD, SHL and SHR.
REQ-015 Port: done  output  1  one-cycle pulse in state DONE.

Function
REQ-016 The FSM SHALL have the states IDLE, ADD, SHL, SHR and DONE; internal registers SHALL be acc, mcand, mplier (all 32 bits) and iter (6 bits).
REQ-017 In IDLE with start=1, the edge SHALL load mcand=multiplicand, mplier=multiplier, acc=0 and iter=0, then go to DONE if multiplier==0 and to ADD otherwise.
REQ-018 In ADD, the block SHALL drive op=ADD, a=acc, b=mcand and shamt=0; the edge SHALL write acc=alu_result only if mplier[0]=1; next state SHALL be SHL.
REQ-019 In SHL, the block SHALL drive op=SLL, a=0, b=mcand and shamt=1; the edge SHALL write mcand=alu_result; next state SHALL be SHR.
REQ-020 In SHR, the block SHALL drive op=SRL, a=0, b=mplier and shamt=1; the edge SHALL write mplier=alu_result and iter=iter+1.
REQ-021 From SHR, next state SHALL be DONE if alu_result==0 or iter+1==32, and ADD otherwise.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; the edge SHALL write product=acc when a multiply completes, and product=0 when DONE is entered directly because Q==0; next state SHALL be IDLE.
REQ-023 In IDLE and DONE, the block SHALL drive op=AND, a=0, b=0 and shamt=0.
REQ-024 All ALU outputs SHALL be combinational functions of the state and registers only, never of start or the operand inputs.
REQ-025 Arithmetic SHALL be modulo 2^32; overflow SHALL be discarded silently.
REQ-026 Latency: let h be the index of the highest set bit of Q; done SHALL assert 3*(h+1)+1 cycles after the accepting edge, or 1 cycle after it when Q==0.
REQ-027 start asserted in ADD, SHL, SHR or DONE SHALL be ignored, with no queueing.
REQ-028 start held high continuously SHALL begin a new multiply on the first IDLE cycle after DONE.
REQ-029 product SHALL NOT change in any state other than DONE, or on reset.

Reset
REQ-030 When reset=1 on an edge, the block SHALL set state=IDLE and acc=mcand=mplier=product=0, iter=0.
REQ-031 With reset asserted, done and busy SHALL read 0 and the ALU outputs SHALL take their IDLE values.
REQ-032 Reset SHALL take priority over start on the same edge.
REQ-033 Reset mid-operation SHALL abort the multiply with no done pulse, and product SHALL read 0.

Verification
REQ-034 Bench SHALL cover: start with M=6, Q=7 -> busy high for 9 cycles, done pulse on the 10th cycle after the accepting edge, product=42.
REQ-035 Bench SHALL cover: start with M=0x12345678, Q=0 -> done 1 cycle after acceptance, busy never high, product=0.
REQ-036 Bench SHALL cover: start with M=0xFFFFFFFF, Q=0xFFFFFFFF -> 32 iterations, done at cycle 97, product=0x00000001.
REQ-037 Bench SHALL cover: start with M=3, Q=0x80000000 -> done at cycle 97, product=0x80000000, acc written exactly once.
REQ-038 Bench SHALL cover: reset pulsed in SHL during M=5, Q=9 -> state IDLE, no done pulse, product=0; a following start with M=5, Q=9 -> product=45.
REQ-039 Bench SHALL cover: start re-pulsed while busy during M=2, Q=3 -> ignored, product=6, exactly one done pulse; the ALU opcode sequence SHALL be checked against ADD, SLL, SRL per iteration.
